// File: rtl/mutative_tag_ctrl.sv
// -----------------------------------------------------------------------------
// mutative_tag_ctrl
//
// Sequencer and arbiter that sits in front of a 2**ADDR_WIDTH x DATA_WIDTH
// single-port tag SRAM.
//
// After reset, and on every flush, the block sweeps every entry to INIT_VALUE.
// During a sweep busy is high and no grants are issued. In normal operation
// the one RW port is shared by a lookup (read) requester and a fill/update
// (write) requester. The write requester has priority. When a read has been
// denied STARVE_LIMIT consecutive cycles, the read wins the next contested
// cycle.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   flush_req    : one-cycle pulse that starts an invalidate sweep (ignored
//                  while a sweep is already running)
//   busy         : high while sweeping
//   rd_req/addr  : read request, held until rd_gnt
//   rd_gnt       : read accepted this cycle (combinational)
//   rd_rvalid    : registered; high the cycle after rd_gnt
//   rd_rdata     : passthrough of sram_dout0
//   wr_req/addr/data : write request, held until wr_gnt
//   wr_gnt       : write accepted this cycle (combinational)
//   sram_*       : SRAM port (csb0/web0 active low), issued in the same
//                  cycle as the grant
// -----------------------------------------------------------------------------
module mutative_tag_ctrl #(
  parameter int unsigned            DATA_WIDTH   = 21,
  parameter int unsigned            ADDR_WIDTH   = 7,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE   = '0,
  parameter int unsigned            STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_req,
  output logic                  busy,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  // Starve counter must be able to hold the value STARVE_LIMIT itself.
  localparam int unsigned STARVE_W =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   sweep_cnt_r;
  logic [ADDR_WIDTH-1:0]   sweep_cnt_nxt_s;
  logic [STARVE_W-1:0]     starve_r;
  logic [STARVE_W-1:0]     starve_nxt_s;
  logic                    rvalid_r;
  logic [ADDR_WIDTH-1:0]   addr_hold_r;
  logic [ADDR_WIDTH-1:0]   addr_nxt_s;
  logic [DATA_WIDTH-1:0]   din_hold_r;
  logic [DATA_WIDTH-1:0]   din_nxt_s;
  logic                    issue_s;
  logic                    write_s;
  logic                    rd_gnt_s;
  logic                    wr_gnt_s;

  // Next-state, arbitration and SRAM command decode.
  always_comb begin
    state_nxt_s     = state_r;
    sweep_cnt_nxt_s = sweep_cnt_r;
    starve_nxt_s    = starve_r;
    rd_gnt_s        = 1'b0;
    wr_gnt_s        = 1'b0;
    issue_s         = 1'b0;
    write_s         = 1'b0;
    addr_nxt_s      = addr_hold_r;
    din_nxt_s       = din_hold_r;

    case (state_r)
      ST_INIT: begin
        // One INIT_VALUE write per cycle; flush_req is deliberately ignored
        // here so a sweep always runs to completion.
        issue_s         = 1'b1;
        write_s         = 1'b1;
        addr_nxt_s      = sweep_cnt_r;
        din_nxt_s       = INIT_VALUE;
        sweep_cnt_nxt_s = sweep_cnt_r + ADDR_WIDTH'(1);
        if (sweep_cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end

      ST_RUN: begin
        if (flush_req) begin
          // Flush masks both requesters this cycle; the port stays idle.
          state_nxt_s     = ST_INIT;
          sweep_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
          starve_nxt_s    = {STARVE_W{1'b0}};
        end else begin
          state_nxt_s = ST_RUN;

          // Write wins a contested cycle unless the read has starved.
          if (rd_req && (!wr_req || (starve_r == STARVE_MAX))) begin
            rd_gnt_s = 1'b1;
          end else if (wr_req) begin
            wr_gnt_s = 1'b1;
          end else begin
            rd_gnt_s = 1'b0;
            wr_gnt_s = 1'b0;
          end

          // With no grant, addr0/din0 keep their previous values.
          if (rd_gnt_s) begin
            issue_s    = 1'b1;
            write_s    = 1'b0;
            addr_nxt_s = rd_addr;
          end else if (wr_gnt_s) begin
            issue_s    = 1'b1;
            write_s    = 1'b1;
            addr_nxt_s = wr_addr;
            din_nxt_s  = wr_data;
          end else begin
            issue_s = 1'b0;
            write_s = 1'b0;
          end

          // Count consecutive denied read cycles, saturating at the limit.
          if (rd_gnt_s) begin
            starve_nxt_s = {STARVE_W{1'b0}};
          end else if (rd_req && (starve_r != STARVE_MAX)) begin
            starve_nxt_s = starve_r + STARVE_W'(1);
          end else begin
            starve_nxt_s = starve_r;
          end
        end
      end

      default: begin
        state_nxt_s     = ST_INIT;
        sweep_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
        starve_nxt_s    = {STARVE_W{1'b0}};
      end
    endcase
  end

  // Control state, sweep/starve counters, read-valid pipe and addr/din hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      sweep_cnt_r <= {ADDR_WIDTH{1'b0}};
      starve_r    <= {STARVE_W{1'b0}};
      rvalid_r    <= 1'b0;
      addr_hold_r <= {ADDR_WIDTH{1'b0}};
      din_hold_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      sweep_cnt_r <= sweep_cnt_nxt_s;
      starve_r    <= starve_nxt_s;
      rvalid_r    <= rd_gnt_s;
      addr_hold_r <= addr_nxt_s;
      din_hold_r  <= din_nxt_s;
    end
  end

  assign busy       = (state_r == ST_INIT);
  assign rd_gnt     = rd_gnt_s;
  assign wr_gnt     = wr_gnt_s;
  assign rd_rvalid  = rvalid_r;
  assign rd_rdata   = sram_dout0;
  // Chip select and write enable are gated by rst_n so the SRAM sees an idle
  // port for as long as reset is held, even though the FSM sits in INIT.
  assign sram_csb0  = ~(issue_s & rst_n);
  assign sram_web0  = ~(write_s & rst_n);
  assign sram_addr0 = addr_nxt_s;
  assign sram_din0  = din_nxt_s;

endmodule

// File: doc/mutative_tag_ctrl.md
Name: mutative_tag_ctrl

Overview:
- Sequencer and arbiter in front of the 128 x 21 single-port tag SRAM.
- After reset, and on every flush, sweeps all entries to INIT_VALUE.
- In normal operation, shares the one RW port between a lookup (read) requester and a fill/update (write) requester.
- Write has priority; a starvation guard guarantees forward progress for reads.

Parameters:
- DATA_WIDTH, 21, tag entry width.
- ADDR_WIDTH, 7, SRAM address width; depth = 2**ADDR_WIDTH.
- INIT_VALUE, 0, value written to every entry during a sweep (valid bit cleared).
- STARVE_LIMIT, 4, consecutive denied read cycles before a read overrides a write.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_req  input  1  single-cycle pulse; start an invalidate sweep.
- busy  output  1  high while sweeping; no grants issued.
- rd_req  input  1  read request; held until rd_gnt.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_gnt  output  1  read accepted this cycle (combinational).
- rd_rvalid  output  1  read data valid; one cycle after rd_gnt.
- rd_rdata  output  DATA_WIDTH  read data; passthrough of sram_dout0.
- wr_req  input  1  write request; held until wr_gnt.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_gnt  output  1  write accepted this cycle (combinational).
- sram_csb0  output  1  SRAM chip select, active low.
- sram_web0  output  1  SRAM write enable, active low.
- sram_addr0  output  ADDR_WIDTH  SRAM address.
- sram_din0  output  DATA_WIDTH  SRAM write data.
- sram_dout0  input  DATA_WIDTH  SRAM read data, valid the cycle after a read issue.

Behaviour:
- States: INIT, RUN.
- Reset values:
  - state = INIT, sweep counter = 0.
  - busy = 1, rd_rvalid = 0, starve counter = 0.
  - rd_gnt = wr_gnt = 0.
  - sram_csb0 = 1, sram_web0 = 1, sram_addr0 = 0, sram_din0 = 0.
- INIT:
  - Each cycle drive csb0=0, web0=0, addr0=counter, din0=INIT_VALUE; counter increments.
  - Issuing counter = 2**ADDR_WIDTH-1 moves to RUN on the next edge; the sweep is exactly 128 cycles.
  - busy=1 and both grants held 0 throughout INIT.
  - flush_req during INIT is ignored; the sweep is not restarted.
- RUN:
  - busy=0.
  - Only wr_req: wr_gnt=1, csb0=0, web0=0, addr0=wr_addr, din0=wr_data.
  - Only rd_req: rd_gnt=1, csb0=0, web0=1, addr0=rd_addr.
  - Both: write wins unless starve counter == STARVE_LIMIT, in which case read wins.
  - Neither: csb0=1, web0=1; addr0 and din0 hold their last values.
  - Starve counter:
    - increments (saturating at STARVE_LIMIT) on each cycle rd_req=1 and rd_gnt=0;
    - clears on rd_gnt;
    - holds when rd_req=0.
  - flush_req in RUN:
    - overrides both requesters that cycle: no grant, csb0=1;
    - next edge enters INIT with counter=0, starve counter cleared.
- Read timing:
  - rd_rvalid is registered and equals the previous cycle's rd_gnt.
  - rd_rdata = sram_dout0 combinationally; it is meaningful only while rd_rvalid=1.
  - Back-to-back reads are allowed, giving one result per cycle.
- Hazards:
  - The SRAM commits a write one edge after issue.
  - A read issued the cycle after a write to the same address returns the new data; the controller adds no stall.
  - A read issued the first RUN cycle after a sweep returns INIT_VALUE for any address, including 127.
- Asynchronous reset mid-sweep or mid-RUN:
  - all state returns to reset values immediately;
  - an in-flight rd_rvalid is dropped;
  - the sweep restarts from 0.
- Grants are combinational from state and requests; requesters must not drop req before gnt.

Test Plan:
- Release rst_n, no requests -> busy=1 for exactly 128 cycles, with addr0 stepping 0..127, web0=0, din0=0. busy=0 on cycle 129, then csb0=1.
- After init, wr 0x1ABCD to addr 5; next cycle rd addr 5 -> wr_gnt, then rd_gnt. rd_rvalid the following cycle with rd_rdata=0x1ABCD.
- rd_req and wr_req held high continuously with distinct addrs -> grant pattern is W,W,W,W,R,W,W,W,W,R,… (read wins after 4 denials).
- Write entries 0..127 with value = addr, pulse flush_req, then read addr 64 after busy falls -> busy=1 for 128 cycles, rd_rdata=0.
- First RUN cycle rd addr 127 immediately after the sweep -> rd_rdata=0, rd_rvalid one cycle after rd_gnt.
- Assert rst_n low at sweep count 60, release -> sweep restarts at addr 0 and runs a full 128 cycles; flush_req pulsed during the sweep has no effect.
